sw_alloc: RTL and testbench

Output-port allocator for the 4×4 packet switch. It watches the flit currently presented by each input (co0..co3), decodes head flits, and arbitrates each output port round-robin among the inputs that request it. It drives the per-output grant vectors ack0..ack3 that steer the crossbar. Each grant is held from the head flit through the tail flit, so the allocator is the request/grant counterpart of the crossbar datapath.

---
 rtl/sw_pkg.sv | 23 ++
 rtl/sw_rr_arb.sv | 74 +++++++
 rtl/sw_alloc.sv | 86 ++++++++
 tb/tb_sw_alloc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the 4x4 packet switch allocator.
//   PKTW   - flit msb (flits are PKTW+1 = 10 bits wide)
//   PORT   - port-vector msb (PORT+1 = 4 ports)
//   NPORT  - number of switch ports
//   FL_*   - flit type codes carried in flit bits [9:8]
//   arb_state_e - per-output allocator FSM states
package sw_pkg;

  localparam int PKTW  = 9;
  localparam int PORT  = 3;
  localparam int NPORT = 4;

  localparam logic [1:0] FL_IDLE = 2'b00;
  localparam logic [1:0] FL_HEAD = 2'b10;
  localparam logic [1:0] FL_BODY = 2'b01;
  localparam logic [1:0] FL_TAIL = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

endpackage

// File: rtl/sw_rr_arb.sv
// sw_rr_arb: round-robin allocator for a single switch output.
// Holds the FSM, the round-robin pointer and the one-hot owner register.
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset
//   req_i   - bit i set = input i requests this output (already masked)
//   tail_i  - the current owner presents a tail flit this cycle
//   gnt_o   - one-hot grant (owner) vector, registered; zero when idle
module sw_rr_arb
  import sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req_i,
  input  logic             tail_i,
  output logic [NPORT-1:0] gnt_o
);

  arb_state_e       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [NPORT-1:0] gnt_q;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       idx;

  // Search the request vector starting at the pointer; the 2-bit index
  // wraps naturally, which gives the modulo-4 rotation.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 0; k < NPORT; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    ptr_d = winner + 2'd1;
  end

  // Grant is taken in IDLE and kept until the owner's tail is seen; heads
  // arriving while BUSY (including a stray head from the owner) are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            gnt_q   <= NPORT'(1) << winner;
            ptr_q   <= ptr_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tail_i) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/sw_alloc.sv
// sw_alloc: output-port allocator for the 4x4 packet switch.
// Decodes head flits on each input, arbitrates every output round-robin
// and holds each grant from head through tail.
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   co0..co3   - flit presented by input i: [9:8] type, [7:0] payload,
//                head destination in payload [1:0]
//   ack0..ack3 - grant vector of output j, bit i = input i owns output j
//   busy       - bit j = output j allocated
module sw_alloc
  import sw_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PKTW:0] co0,
  input  logic [PKTW:0] co1,
  input  logic [PKTW:0] co2,
  input  logic [PKTW:0] co3,
  output logic [PORT:0] ack0,
  output logic [PORT:0] ack1,
  output logic [PORT:0] ack2,
  output logic [PORT:0] ack3,
  output logic [PORT:0] busy
);

  logic [NPORT-1:0][1:0]       flitType;
  logic [NPORT-1:0][1:0]       flitDest;
  logic [NPORT-1:0][NPORT-1:0] gnt;
  logic [NPORT-1:0][NPORT-1:0] req;
  logic [NPORT-1:0]            granted;
  logic [NPORT-1:0]            isTail;

  assign flitType[0] = co0[PKTW:PKTW-1];
  assign flitType[1] = co1[PKTW:PKTW-1];
  assign flitType[2] = co2[PKTW:PKTW-1];
  assign flitType[3] = co3[PKTW:PKTW-1];
  assign flitDest[0] = co0[1:0];
  assign flitDest[1] = co1[1:0];
  assign flitDest[2] = co2[1:0];
  assign flitDest[3] = co3[1:0];

  // An input already owning some output must not raise a new request, so the
  // owner's own head (still visible the cycle after its grant) is never
  // arbitrated a second time.
  always_comb begin
    granted = '0;
    isTail  = '0;
    req     = '0;
    for (int j = 0; j < NPORT; j++) begin
      granted = granted | gnt[j];
    end
    for (int i = 0; i < NPORT; i++) begin
      isTail[i] = (flitType[i] == FL_TAIL);
    end
    for (int j = 0; j < NPORT; j++) begin
      for (int i = 0; i < NPORT; i++) begin
        req[j][i] = (flitType[i] == FL_HEAD) && (flitDest[i] == 2'(j)) &&
                    !granted[i];
      end
    end
  end

  for (genvar j = 0; j < NPORT; j++) begin : g_arb
    // The grant is one-hot, so masking the tail vector picks the owner's tail.
    sw_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_i  (req[j]),
      .tail_i (|(gnt[j] & isTail)),
      .gnt_o  (gnt[j])
    );
  end

  assign ack0 = gnt[0];
  assign ack1 = gnt[1];
  assign ack2 = gnt[2];
  assign ack3 = gnt[3];

  always_comb begin
    busy = '0;
    for (int j = 0; j < NPORT; j++) begin
      busy[j] = |gnt[j];
    end
  end

endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc: self-checking bench for sw_alloc.
// Each input is fed from a flit queue that advances only while the input owns
// an output (idle flits drain freely); a behavioural model tracks owner and
// pointer per output as integers and is compared against the DUT every cycle.
module tb_sw_alloc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] co0, co1, co2, co3;
  logic [3:0] ack0, ack1, ack2, ack3, busy;

  always #5 clk = ~clk;

  sw_alloc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .co0   (co0),
    .co1   (co1),
    .co2   (co2),
    .co3   (co3),
    .ack0  (ack0),
    .ack1  (ack1),
    .ack2  (ack2),
    .ack3  (ack3),
    .busy  (busy)
  );

  logic [9:0] srcQ [4][$];
  int         owner [4];
  int         ptr   [4];
  logic       rstVal;
  int         total = 0;
  int         bad   = 0;

  function automatic logic [9:0] front(int i);
    if (srcQ[i].size() > 0) return srcQ[i][0];
    return 10'h000;
  endfunction

  function automatic logic [3:0] modelAck(int j);
    if (owner[j] < 0) return 4'b0000;
    return 4'(1 << owner[j]);
  endfunction

  function automatic logic [3:0] modelBusy();
    return {owner[3] >= 0, owner[2] >= 0, owner[1] >= 0, owner[0] >= 0};
  endfunction

  task automatic checkOutput(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    rst_n = rstVal;
    co0   = front(0);
    co1   = front(1);
    co2   = front(2);
    co3   = front(3);
  endtask

  task automatic clearQueues();
    for (int i = 0; i < 4; i++) srcQ[i].delete();
  endtask

  // Queue one packet: head to dest, nBody body flits, tail.
  task automatic pushPacket(int i, int dest, int nBody, bit withIdles);
    srcQ[i].push_back({2'b10, 6'($urandom), 2'(dest)});
    for (int b = 0; b < nBody; b++) begin
      if (withIdles && $urandom_range(0, 3) == 0)
        srcQ[i].push_back({2'b00, 8'($urandom)});
      srcQ[i].push_back({2'b01, 8'($urandom)});
    end
    srcQ[i].push_back({2'b11, 8'($urandom)});
  endtask

  // Model reaction to one rising edge, from the flits presented this cycle.
  task automatic modelEdge();
    logic [9:0] cur [4];
    bit         owned [4];
    for (int i = 0; i < 4; i++) begin
      cur[i]   = front(i);
      owned[i] = 1'b0;
    end
    for (int j = 0; j < 4; j++)
      if (owner[j] >= 0) owned[owner[j]] = 1'b1;
    if (!rstVal) begin
      for (int j = 0; j < 4; j++) begin
        owner[j] = -1;
        ptr[j]   = 0;
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (owner[j] >= 0) begin
          if (cur[owner[j]][9:8] == 2'b11) owner[j] = -1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr[j] + k) % 4;
            if (cur[i][9:8] == 2'b10 && int'(cur[i][1:0]) == j && !owned[i]) begin
              owner[j] = i;
              ptr[j]   = (i + 1) % 4;
              break;
            end
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (srcQ[i].size() > 0 && (owned[i] || cur[i][9:8] == 2'b00))
          void'(srcQ[i].pop_front());
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare.
  task automatic cycle();
    applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("ack0", ack0, modelAck(0));
    checkOutput("ack1", ack1, modelAck(1));
    checkOutput("ack2", ack2, modelAck(2));
    checkOutput("ack3", ack3, modelAck(3));
    checkOutput("busy", busy, modelBusy());
  endtask

  task automatic doReset();
    rstVal = 1'b0;
    clearQueues();
    cycle();
    cycle();
    rstVal = 1'b1;
  endtask

  logic [3:0] contExp [12] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2,
                               4'h2, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};

  initial begin
    for (int j = 0; j < 4; j++) begin
      owner[j] = -1;
      ptr[j]   = 0;
    end

    // Reset with a head to output 3 waiting, then a head-tail packet.
    rstVal = 1'b0;
    clearQueues();
    pushPacket(0, 3, 0, 1'b0);
    cycle();
    cycle();
    checkOutput("rst_ack3", ack3, 4'b0000);
    checkOutput("rst_busy", busy, 4'b0000);
    rstVal = 1'b1;
    cycle();
    checkOutput("rel_ack3", ack3, 4'b0001);
    cycle();
    checkOutput("ht0_ack3_c2", ack3, 4'b0001);
    cycle();
    checkOutput("ht0_ack3_off", ack3, 4'b0000);

    // Single packet, four bodies: grant spans head-forward..tail = 6 cycles.
    doReset();
    pushPacket(0, 3, 4, 1'b0);
    for (int c = 0; c < 7; c++) begin
      cycle();
      checkOutput($sformatf("single_ack3_%0d", c), ack3, (c < 6) ? 4'b0001 : 4'b0000);
    end

    // Three-way contention on output 2.
    doReset();
    pushPacket(0, 2, 1, 1'b0);
    pushPacket(1, 2, 1, 1'b0);
    pushPacket(2, 2, 1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      cycle();
      checkOutput($sformatf("cont_ack2_%0d", c), ack2, contExp[c]);
    end

    // Four disjoint paths granted on the same edge.
    doReset();
    pushPacket(0, 3, 1, 1'b0);
    pushPacket(1, 2, 1, 1'b0);
    pushPacket(2, 1, 1, 1'b0);
    pushPacket(3, 0, 1, 1'b0);
    cycle();
    checkOutput("par_ack3", ack3, 4'b0001);
    checkOutput("par_ack2", ack2, 4'b0010);
    checkOutput("par_ack1", ack1, 4'b0100);
    checkOutput("par_ack0", ack0, 4'b1000);
    checkOutput("par_busy", busy, 4'b1111);
    for (int c = 0; c < 4; c++) cycle();

    // Head-tail packet from input 3 to output 0.
    doReset();
    pushPacket(3, 0, 0, 1'b0);
    cycle();
    checkOutput("ht3_ack0_c1", ack0, 4'b1000);
    cycle();
    checkOutput("ht3_ack0_c2", ack0, 4'b1000);
    cycle();
    checkOutput("ht3_ack0_off", ack0, 4'b0000);

    // Reset in the middle of a packet; pointer must restart at 0.
    doReset();
    pushPacket(0, 3, 4, 1'b0);
    cycle();
    cycle();
    cycle();
    checkOutput("mid_ack3_before", ack3, 4'b0001);
    rstVal = 1'b0;
    cycle();
    checkOutput("mid_ack3_rst", ack3, 4'b0000);
    checkOutput("mid_busy_rst", busy, 4'b0000);
    clearQueues();
    rstVal = 1'b1;
    pushPacket(0, 3, 0, 1'b0);
    pushPacket(1, 3, 0, 1'b0);
    cycle();
    checkOutput("mid_regrant_ack3", ack3, 4'b0001);
    for (int c = 0; c < 8; c++) cycle();

    // Random traffic with occasional resets.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (srcQ[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          for (int g = $urandom_range(0, 2); g > 0; g--)
            srcQ[i].push_back({2'b00, 8'($urandom)});
          pushPacket(i, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
        end
      end
      rstVal = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cycle();
      if (!rstVal) clearQueues();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
